// File: rtl/core_v4_pkg.sv
// Shared types and constants for the v4 sequenced RV32I ALU core.
// ALU op codes are {funct7[5], funct3} so decode is a direct bit slice.
package core_v4_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t S_IDLE   = 3'd0;
  localparam fsm_state_t S_FETCH  = 3'd1;
  localparam fsm_state_t S_DECODE = 3'd2;
  localparam fsm_state_t S_EXEC   = 3'd3;
  localparam fsm_state_t S_WB     = 3'd4;
  localparam fsm_state_t S_HALT   = 3'd5;

  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

endpackage

// File: rtl/core_seq_v4_alu.sv
// Combinational integer ALU for the v4 core.
// Shift amount is the low log2(XLEN) bits of operand b.
module alu_v4
  import core_v4_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  logic          lt_s;
  logic          lt_u;

  assign sh   = b_i[SW-1:0];
  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << sh;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> sh;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/core_seq_v4.sv
// Multi-cycle RV32I integer-ALU core: imem, regfile and ALU
// behind a FETCH/DECODE/EXEC/WB sequencer with start/halt control.
module core_seq_v4
  import core_v4_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          store_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] store_address,
  input  logic [31:0]                   store_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [3:0]                    opcode,
  output logic [XLEN-1:0]               alu_data_out,
  output logic                          wb_valid,
  output logic [4:0]                    wb_rd,
  output logic [CNT_W-1:0]              retired_cnt,
  input  logic [4:0]                    dbg_rd_addr,
  output logic [XLEN-1:0]               dbg_rd_data
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [AW-1:0] PC_LAST = AW'(IMEM_DEPTH - 1);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] regs_q [32];

  fsm_state_t      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [XLEN-1:0] alu_q, alu_d;
  alu_op_t         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            rf_we;
  logic            store_ok;
  logic [XLEN-1:0] alu_y;

  logic [6:0]      rv_op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [5:0]      f6;
  logic            is_ecall;
  logic            sh_hi_ok;
  logic            op_legal;
  logic            imm_legal;
  logic            legal;
  alu_op_t         dec_op;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rv_op = instr_q[6:0];
  assign f3    = instr_q[14:12];
  assign f7    = instr_q[31:25];
  assign f6    = instr_q[31:26];

  assign is_ecall = instr_q == ECALL_WORD;
  // shamt[5] lives in instr[25]; only meaningful when XLEN is 64
  assign sh_hi_ok = (XLEN == 64) || !instr_q[25];

  assign op_legal = (rv_op == OPC_OP) &&
    ((f7 == F7_BASE) ||
     ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));

  assign imm_legal = (rv_op == OPC_OPIMM) &&
    ((f3 == F3_SLL) ? ((f6 == 6'h00) && sh_hi_ok) :
     (f3 == F3_SR)  ? (((f6 == 6'h00) || (f6 == 6'h10)) && sh_hi_ok) :
     1'b1);

  assign legal = op_legal || imm_legal;

  assign dec_op = alu_op_t'({
    ((rv_op == OPC_OP) || (f3 == F3_SR)) & instr_q[30], f3});

  assign imm     = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign rs1_val = regs_q[instr_q[19:15]];
  assign rs2_val = regs_q[instr_q[24:20]];

  assign store_ok = store_en &&
    ((state_q == S_IDLE) || (state_q == S_HALT));

  alu_v4 #(.XLEN(XLEN)) u_alu (
    .a_i  (op1_q),
    .b_i  (op2_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    alu_d   = alu_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    rf_we   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
          ill_d   = 1'b0;
        end
      end
      S_FETCH: begin
        instr_d = imem[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_ecall: state_d = S_HALT;
          legal: begin
            op1_d   = rs1_val;
            op2_d   = op_legal ? rs2_val : imm;
            op_d    = dec_op;
            rd_d    = instr_q[11:7];
            state_d = S_EXEC;
          end
          default: begin
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        alu_d   = alu_y;
        state_d = S_WB;
      end
      S_WB: begin
        rf_we = rd_q != 5'd0;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (pc_q == PC_LAST) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      alu_q   <= '0;
      op_q    <= ALU_ADD;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      alu_q   <= alu_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_q] <= alu_q;
    end
  end

  // program store survives reset
  always_ff @(posedge clk) begin
    if (store_ok) imem[store_address] <= store_data;
  end

  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted       = state_q == S_HALT;
  assign illegal      = ill_q;
  assign opcode       = op_q;
  assign alu_data_out = alu_q;
  assign wb_valid     = state_q == S_WB;
  assign wb_rd        = rd_q;
  assign retired_cnt  = cnt_q;
  assign dbg_rd_data  = (dbg_rd_addr == 5'd0) ? '0 : regs_q[dbg_rd_addr];

endmodule

// File: tb/tb_core_seq_v4.sv
// Bench for core_seq_v4: ISA-level model predicts every writeback
// and the final architectural state of each run.
module tb_core_seq_v4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        store_en = 1'b0;
  logic [5:0]  store_address = '0;
  logic [31:0] store_data = '0;
  logic        start = 1'b0;
  logic        busy, halted, illegal, wb_valid;
  logic [3:0]  opcode;
  logic [31:0] alu_data_out, retired_cnt, dbg_rd_data;
  logic [4:0]  wb_rd;
  logic [4:0]  dbg_rd_addr = '0;

  core_seq_v4 #(.XLEN(32), .IMEM_DEPTH(64), .CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .store_en      (store_en),
    .store_address (store_address),
    .store_data    (store_data),
    .start         (start),
    .busy          (busy),
    .halted        (halted),
    .illegal       (illegal),
    .opcode        (opcode),
    .alu_data_out  (alu_data_out),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .retired_cnt   (retired_cnt),
    .dbg_rd_addr   (dbg_rd_addr),
    .dbg_rd_data   (dbg_rd_data)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit saw_x0 = 1'b0;

  logic [31:0] m_imem [64];
  logic [31:0] m_regs [32];
  int          m_cnt;
  bit          m_ill;
  logic [4:0]  q_rd [$];
  logic [31:0] q_v [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RV32I semantics of the supported subset; ok=0 for anything else
  function automatic logic [31:0] isa_exec(input logic [31:0] w,
      input logic [31:0] a, input logic [31:0] r2, output bit ok);
    logic [6:0]  opc = w[6:0];
    logic [2:0]  fn3 = w[14:12];
    logic [6:0]  fn7 = w[31:25];
    logic [31:0] imm = {{20{w[31]}}, w[31:20]};
    logic [31:0] b;
    logic [4:0]  sh;
    ok = 1'b1;
    b  = (opc == 7'h33) ? r2 : imm;
    sh = b[4:0];
    if (opc == 7'h13) begin
      if (fn3 == 3'd1 && fn7 != 7'h00) ok = 1'b0;
      if (fn3 == 3'd5 && fn7 != 7'h00 && fn7 != 7'h20) ok = 1'b0;
    end else if (opc == 7'h33) begin
      if (fn7 != 7'h00 &&
          !(fn7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5))) ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    case (fn3)
      3'd0: return (opc == 7'h33 && fn7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return fn7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_run();
    logic [31:0] w, v;
    bit ok;
    m_cnt = 0;
    m_ill = 1'b0;
    for (int pc = 0; pc < 64; pc++) begin
      w = m_imem[pc];
      if (w == 32'h0000_0073) break;
      v = isa_exec(w, m_regs[w[19:15]], m_regs[w[24:20]], ok);
      if (!ok) begin
        m_ill = 1'b1;
        break;
      end
      q_rd.push_back(w[11:7]);
      q_v.push_back(v);
      if (w[11:7] != 5'd0) m_regs[w[11:7]] = v;
      m_cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      if (q_rd.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL wb_unexpected: got rd %0d data %0h want none",
                 wb_rd, alu_data_out);
      end else begin
        chk("wb_rd", wb_rd, q_rd.pop_front());
        chk("wb_data", alu_data_out, q_v.pop_front());
        if (wb_rd == 5'd0) saw_x0 = 1'b1;
      end
    end
  end

  task automatic load(input int a, input logic [31:0] w);
    store_en      = 1'b1;
    store_address = 6'(a);
    store_data    = w;
    m_imem[a]     = w;
    tick();
    store_en = 1'b0;
  endtask

  task automatic launch();
    model_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal_clear", illegal, 0);
    chk("busy_run", busy, 1);
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (!halted && n < 400) begin
      tick();
      n++;
    end
    chk({nm, "_halted"}, halted, 1);
  endtask

  function automatic logic [31:0] dbg(input int i);
    return m_regs[i];
  endfunction

  task automatic rd_reg(input int i, output logic [31:0] v);
    dbg_rd_addr = 5'(i);
    #1;
    v = dbg_rd_data;
  endtask

  task automatic final_chk(input string nm);
    logic [31:0] v;
    chk({nm, "_illegal"}, illegal, m_ill);
    chk({nm, "_retired"}, retired_cnt, m_cnt);
    chk({nm, "_wb_left"}, q_rd.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    for (int i = 0; i < 32; i++) begin
      rd_reg(i, v);
      chk($sformatf("%s_x%0d", nm, i), v, dbg(i));
    end
  endtask

  task automatic load_prog1();
    load(0, 32'h0050_0093);
    load(1, 32'hFFD0_0113);
    load(2, 32'h0020_81B3);
    load(3, 32'h4020_8233);
    load(4, 32'h0000_0073);
  endtask

  initial begin
    logic [31:0] v;
    int lat;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 64; i++) m_imem[i] = '0;

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu", alu_data_out, 0);
    chk("rst_retired", retired_cnt, 0);
    chk("rst_wb_valid", wb_valid, 0);
    reset_n = 1'b1;
    tick();

    // scenario 1: basic program and WB latency
    load_prog1();
    launch();
    lat = 1;
    while (!wb_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("wb_latency", lat, 4);
    wait_halt("s1");
    final_chk("s1");
    rd_reg(1, v); chk("s1_x1_lit", v, 32'h5);
    rd_reg(2, v); chk("s1_x2_lit", v, 32'hFFFF_FFFD);
    rd_reg(3, v); chk("s1_x3_lit", v, 32'h2);
    rd_reg(4, v); chk("s1_x4_lit", v, 32'h8);
    chk("s1_retired_lit", retired_cnt, 4);

    // scenario 2: arithmetic shift and signed/unsigned compare
    load(0, 32'h4011_5293);
    load(1, 32'h0011_3333);
    load(2, 32'h0011_23B3);
    load(3, 32'h0000_0073);
    launch();
    wait_halt("s2");
    final_chk("s2");
    rd_reg(5, v); chk("s2_srai_lit", v, 32'hFFFF_FFFE);
    rd_reg(6, v); chk("s2_sltu_lit", v, 32'h0);
    rd_reg(7, v); chk("s2_slt_lit", v, 32'h1);

    // scenario 3: illegal word, then restart clears the flag
    load(0, 32'h00A0_0413);
    load(1, 32'h0000_0000);
    launch();
    wait_halt("s3");
    final_chk("s3");
    chk("s3_illegal_lit", illegal, 1);
    chk("s3_retired_lit", retired_cnt, 1);
    launch();
    wait_halt("s3b");
    final_chk("s3b");

    // scenario 4: write to x0
    load(0, 32'h0070_0013);
    load(1, 32'h0000_0073);
    saw_x0 = 1'b0;
    launch();
    wait_halt("s4");
    final_chk("s4");
    chk("s4_x0_wb_seen", saw_x0, 1);
    rd_reg(0, v); chk("s4_x0_lit", v, 32'h0);

    // scenario 5: store dropped while busy, store+start lands
    load(0, 32'h0030_0493);
    load(1, 32'h0000_0073);
    launch();
    tick();
    tick();
    store_en      = 1'b1;
    store_address = 6'd1;
    store_data    = 32'h0010_0513;
    tick();
    store_en = 1'b0;
    wait_halt("s5");
    final_chk("s5");
    chk("s5_drop_retired_lit", retired_cnt, 1);
    store_en      = 1'b1;
    store_address = 6'd0;
    store_data    = 32'h02A0_0593;
    m_imem[0]     = 32'h02A0_0593;
    model_run();
    start = 1'b1;
    tick();
    start    = 1'b0;
    store_en = 1'b0;
    wait_halt("s5b");
    final_chk("s5b");
    rd_reg(11, v); chk("s5_new_word_lit", v, 32'd42);

    // scenario 6: reset in EXEC, rerun, full-depth program
    load_prog1();
    launch();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    q_rd.delete();
    q_v.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_halted", halted, 0);
    chk("s6_rst_alu", alu_data_out, 0);
    chk("s6_rst_opcode", opcode, 0);
    chk("s6_rst_retired", retired_cnt, 0);
    chk("s6_rst_wb", wb_valid, 0);
    rd_reg(1, v); chk("s6_rst_x1", v, 0);
    tick();
    reset_n = 1'b1;
    tick();
    launch();
    wait_halt("s6");
    final_chk("s6");
    rd_reg(4, v); chk("s6_x4_lit", v, 32'h8);
    for (int i = 0; i < 64; i++) load(i, 32'h0016_0613);
    launch();
    wait_halt("s6b");
    final_chk("s6b");
    chk("s6_full_retired_lit", retired_cnt, 64);
    rd_reg(12, v); chk("s6_x12_lit", v, 32'd64);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
